// File: rtl/frame_cmd_scheduler.sv
// Frame command scheduler: queues Avalon-written commands and commit markers, broadcasts
// commands to display components and performs the front/back buffer swap in vertical blank.
module frame_cmd_scheduler #(
  parameter int DEPTH       = 16,
  parameter int VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf,
  output logic        swap_done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT_VB, SWAP} state_t;

  state_t         state;
  logic [32:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow;

  logic        empty, full, push, pop, push_ok, drop, in_vblank;
  logic [32:0] head, push_word;
  logic [31:0] status;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head      = mem[rd_ptr];
  assign push      = chipselect && write;
  assign pop       = (state == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign push_word = address ? {1'b1, 32'h0} : {1'b0, writedata};
  assign in_vblank = ({22'd0, vcount} >= 32'(VBLANK_LINE));
  assign status    = {16'h0, overflow, front_buf, (state == WAIT_VB), full, empty,
                      3'b000, 8'(count)};

  // Storage needs no reset: validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      readdata <= 32'h0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                      overflow <= 1'b1;
      else if (chipselect && read)   overflow <= 1'b0;
      if (chipselect && read) readdata <= status;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_out   <= 32'h0;
      front_buf <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      cmd_out   <= 32'h0;
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head[32]) state <= WAIT_VB;
            else          cmd_out <= {head[31:14], ~front_buf, head[12:0]};
          end
        end
        WAIT_VB: begin
          if (in_vblank) begin
            state   <= SWAP;
            cmd_out <= 32'h001E0000 | {18'h0, ~front_buf, 13'h0};
          end
        end
        SWAP: begin
          state     <= IDLE;
          front_buf <= ~front_buf;
          swap_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Bench for frame_cmd_scheduler: directed scenarios then random traffic, all checked
// every cycle against a queue-based reference model.
module tb_frame_cmd_scheduler;
  localparam int DEPTH = 16;
  localparam int VBL   = 480;

  logic        clk, rst_n, cs, wr, rd, addr;
  logic [31:0] wdata, readdata, cmd_out;
  logic [9:0]  vcount;
  logic        front_buf, swap_done;

  int checks = 0;
  int errors = 0;

  frame_cmd_scheduler #(.DEPTH(DEPTH), .VBLANK_LINE(VBL)) dut (
    .clk(clk), .reset(rst_n), .chipselect(cs), .write(wr), .read(rd), .address(addr),
    .writedata(wdata), .readdata(readdata), .vcount(vcount), .cmd_out(cmd_out),
    .front_buf(front_buf), .swap_done(swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = dispatching, 1 = waiting for vblank, 2 = swapping.
  logic [32:0] q[$];
  int          m_phase;
  bit          m_front, m_swap, m_ovf;
  logic [31:0] m_cmd, m_rd;

  task automatic mreset();
    q.delete();
    m_phase = 0; m_front = 0; m_swap = 0; m_ovf = 0; m_cmd = 32'h0; m_rd = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    cs = 0; wr = 0; rd = 0; addr = 0; wdata = 32'h0;
  endtask

  task automatic put(input logic a, input logic [31:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; wdata = d;
  endtask

  task automatic tick();
    logic push, pop, drop, full;
    logic [32:0] head;
    logic [31:0] n_cmd, status;
    bit n_swap, n_front;
    int n_phase;
    push = cs && wr; full = (q.size() == DEPTH); pop = 0;
    n_cmd = 32'h0; n_swap = 0; n_front = m_front; n_phase = m_phase;
    status = {16'h0, m_ovf, m_front, (m_phase == 1), full, (q.size() == 0), 3'b000,
              8'(q.size())};
    case (m_phase)
      0: if (q.size() > 0) begin
           pop = 1; head = q[0];
           if (head[32]) n_phase = 1;
           else begin
             n_cmd = head[31:0];
             n_cmd[13] = ~m_front;
           end
         end
      1: if (vcount >= VBL) begin
           n_phase = 2;
           n_cmd = m_front ? 32'h001E0000 : 32'h001E2000;
         end
      default: begin n_phase = 0; n_front = ~m_front; n_swap = 1; end
    endcase
    drop = push && full && !pop;
    if (cs && rd) m_rd = status;
    if (drop) m_ovf = 1;
    else if (cs && rd) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(addr ? {1'b1, 32'h0} : {1'b0, wdata});
    m_cmd = n_cmd; m_swap = n_swap; m_front = n_front; m_phase = n_phase;
    @(posedge clk); #1;
    chk("cmd_out", cmd_out, m_cmd);
    chk("front_buf", {31'h0, front_buf}, {31'h0, m_front});
    chk("swap_done", {31'h0, swap_done}, {31'h0, m_swap});
    chk("readdata", readdata, m_rd);
  endtask

  initial begin
    rst_n = 0; vcount = 10'd0; idle_in(); mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_out", cmd_out, 32'h0);
    chk("rst_front", {31'h0, front_buf}, 32'h0);
    chk("rst_swap", {31'h0, swap_done}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    rst_n = 1;

    // Single command: visible two edges after the write, for one cycle only.
    put(0, 32'h38228005); tick();
    idle_in(); tick();
    chk("first_cmd", cmd_out, 32'h3822A005);
    tick();
    chk("first_cmd_gone", cmd_out, 32'h0);

    // Commit outside vblank, queued command waits behind the swap.
    vcount = 10'd100;
    put(1, 32'h0); tick();
    put(0, 32'h00002ABC); tick();
    idle_in(); repeat (4) tick();
    chk("wait_no_out", cmd_out, 32'h0);
    vcount = 10'd480; tick();
    chk("swap_word", cmd_out, 32'h001E2000);
    tick();
    chk("swap_pulse", {31'h0, swap_done}, 32'h1);
    chk("front_after", {31'h0, front_buf}, 32'h1);
    tick();
    chk("post_swap_cmd", cmd_out, 32'h00000ABC);

    // Commit already inside vblank: swap two cycles after the write.
    vcount = 10'd500;
    put(1, 32'h0); tick();
    idle_in(); tick(); tick();
    chk("vb_swap_word", cmd_out, 32'h001E0000);
    tick(); tick();

    // Fill the FIFO while stalled in WAIT_VB, then overflow.
    vcount = 10'd0;
    put(1, 32'h0); tick();
    for (int i = 0; i < 17; i++) begin
      put(0, 32'hA000_0000 + i); tick();
    end
    cs = 1; wr = 0; rd = 1; tick();
    chk("ovf_flag", {31'h0, readdata[15]}, 32'h1);
    chk("full_flag", {31'h0, readdata[12]}, 32'h1);
    tick();
    chk("ovf_cleared", {31'h0, readdata[15]}, 32'h0);

    // Push and pop together at count=DEPTH.
    vcount = 10'd480; idle_in(); tick(); tick();
    cs = 1; wr = 1; rd = 1; addr = 0; wdata = 32'h0BAD_F00D; tick();
    cs = 1; wr = 0; rd = 1; tick();
    chk("pp_count", {24'h0, readdata[7:0]}, 32'd16);
    chk("pp_ovf", {31'h0, readdata[15]}, 32'h0);
    idle_in(); repeat (20) tick();

    // Asynchronous reset while a swap is pending with queued commands.
    vcount = 10'd0;
    put(1, 32'h0); tick();
    for (int i = 0; i < 5; i++) begin
      put(0, 32'h5500_0000 + i); tick();
    end
    idle_in(); tick();
    #2 rst_n = 0;
    #1;
    chk("arst_cmd_out", cmd_out, 32'h0);
    chk("arst_front", {31'h0, front_buf}, 32'h0);
    chk("arst_readdata", readdata, 32'h0);
    mreset();
    @(posedge clk); #1;
    rst_n = 1; vcount = 10'd480;
    repeat (6) tick();
    cs = 1; rd = 1; tick();
    chk("arst_count", {24'h0, readdata[7:0]}, 32'd0);
    idle_in();

    // Random traffic with a wandering scanline.
    for (int n = 0; n < 500; n++) begin
      cs    = ($urandom % 4) != 0;
      wr    = $urandom % 2;
      rd    = ($urandom % 3) == 0;
      addr  = ($urandom % 10) == 0;
      wdata = $urandom;
      vcount = 10'((32'(vcount) + $urandom_range(0, 40)) % 525);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
